top_tdr_creation_tessent_data_mux_sync: RTL

Parametrised, registered successor of the 2-bit IJTAG/functional data mux. Provides NUM_CH independent channels of WIDTH bits. Each channel switches between functional and IJTAG sources through a break-before-make hold phase, so a source change never corrupts the driven signal. Also offers a functional-data capture register for TDR readback. Sits between TDR update stages and the functional logic it overrides.

---
 rtl/top_tdr_creation_tessent_data_mux_sync.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/top_tdr_creation_tessent_data_mux_sync.sv
// Registered multi-channel IJTAG/functional data mux with break-before-make
// source switching and a functional-data capture register for TDR readback.
//
// Per-channel FSM:
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_FUNC  | functional source drives data_out, tracked every edge
//   ST_H2I   | hold phase towards IJTAG, data_out frozen, busy
//   ST_IJTAG | IJTAG source drives data_out, tracked every edge
//   ST_H2F   | hold phase towards functional, data_out frozen, busy
module top_tdr_creation_tessent_data_mux_sync #(
  parameter int unsigned      WIDTH       = 2,
  parameter int unsigned      NUM_CH      = 4,
  parameter int unsigned      SETTLE      = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic                    ijtag_tck,
  input  logic                    ijtag_reset,
  input  logic [NUM_CH-1:0]       ijtag_select,
  input  logic [NUM_CH*WIDTH-1:0] functional_data_in,
  input  logic [NUM_CH*WIDTH-1:0] ijtag_data_in,
  input  logic                    capture_en,
  output logic [NUM_CH*WIDTH-1:0] data_out,
  output logic [NUM_CH-1:0]       select_active,
  output logic [NUM_CH-1:0]       switch_busy,
  output logic [NUM_CH*WIDTH-1:0] captured_func
);

  localparam int unsigned    CW       = $clog2(SETTLE + 1);
  // Counter starts at SETTLE-1 and the exit happens on the edge that sees
  // zero, so the hold phase lasts exactly SETTLE cycles.
  localparam logic [CW-1:0]  CNT_LOAD = CW'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_FUNC  = 2'd0,
    ST_H2I   = 2'd1,
    ST_IJTAG = 2'd2,
    ST_H2F   = 2'd3
  } state_e;

  logic [NUM_CH*WIDTH-1:0] captured_func_q;
  logic [NUM_CH*WIDTH-1:0] captured_func_d;

  // Capture samples the raw functional input, not the muxed output.
  always_comb begin
    captured_func_d = captured_func_q;
    if (capture_en) begin
      captured_func_d = functional_data_in;
    end
  end

  // Capture register.
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      captured_func_q <= '0;
    end else begin
      captured_func_q <= captured_func_d;
    end
  end

  assign captured_func = captured_func_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : gen_ch
    state_e           state_q;
    state_e           state_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             sel;
    logic [WIDTH-1:0] func_in;
    logic [WIDTH-1:0] ijtag_in;

    assign sel      = ijtag_select[c];
    assign func_in  = functional_data_in[c*WIDTH +: WIDTH];
    assign ijtag_in = ijtag_data_in[c*WIDTH +: WIDTH];

    // Next-state, hold counter and output data for one channel.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      case (state_q)
        ST_FUNC: begin
          if (sel) begin
            state_d = ST_H2I;
            cnt_d   = CNT_LOAD;
          end else begin
            data_d = func_in;
          end
        end
        ST_H2I: begin
          if (!sel) begin
            state_d = ST_FUNC;
          end else if (cnt_q == '0) begin
            state_d = ST_IJTAG;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        ST_IJTAG: begin
          if (!sel) begin
            state_d = ST_H2F;
            cnt_d   = CNT_LOAD;
          end else begin
            data_d = ijtag_in;
          end
        end
        ST_H2F: begin
          if (sel) begin
            state_d = ST_IJTAG;
          end else if (cnt_q == '0) begin
            state_d = ST_FUNC;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: begin
          state_d = ST_FUNC;
        end
      endcase
    end

    // Channel state, counter and output registers.
    always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
      if (!ijtag_reset) begin
        state_q <= ST_FUNC;
        cnt_q   <= '0;
        data_q  <= RESET_VALUE;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        data_q  <= data_d;
      end
    end

    // Status is a pure decode of the state flop, so it moves with the state.
    assign data_out[c*WIDTH +: WIDTH] = data_q;
    assign select_active[c] = (state_q == ST_IJTAG) || (state_q == ST_H2F);
    assign switch_busy[c]   = (state_q == ST_H2I) || (state_q == ST_H2F);
  end

endmodule
